inta_cascade_sequencer: RTL and testbench
=========================================

// Module: inta_cascade_sequencer
// PURPOSE
//  Sequences the two-pulse INTA acknowledge cycle and the CAS[2:0] cascade bus of the PIC.
//  As master: latches the resolved IR, drives the slave ID on CAS and releases its own vector only for non-cascaded IRs.
//  As slave: matches CAS against its ICW3 ID and releases the vector on the second INTA.
//  Sits between the priority resolver/ISR logic and the data-bus buffer / CAS pins.
// PARAMETERS
//  SYNC_STAGES  2   flops in the inta_n synchronizer (>=2)
//  GAP_TIMEOUT  64  max clk cycles allowed between INTA pulses before abort (>=2)
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  rst         in   1  asynchronous, active-high reset
//  inta_n      in   1  CPU acknowledge, asynchronous, active low
//  sp_en_n     in   1  SP/EN pin: 1 = master, 0 = slave (non-buffered mode)
//  buf_mode    in   1  ICW4 BUF; when 1 the mode comes from buf_ms instead of sp_en_n
//  buf_ms      in   1  ICW4 M/S: 1 = master
//  slave_map   in   8  ICW3 master: bit i = 1 means a slave hangs on IR i
//  slave_id    in   3  ICW3 slave: own cascade ID
//  int_req     in   1  priority resolver has a pending unmasked request
//  int_level   in   3  highest-priority pending IR
//  cas_in      in   3  CAS pins as sampled (slave side)
//  cas_out     out  3  CAS value driven by master
//  cas_oe      out  1  CAS output enable
//  isr_set     out  1  one-cycle pulse: set ISR bit isr_level
//  isr_level   out  3  latched acknowledged IR
//  vec_oe      out  1  release vector onto data bus (second INTA)
//  spurious    out  1  level flag: current cycle is spurious (IR7 vector, no ISR)
//  ack_abort   out  1  one-cycle pulse: gap timeout
// BEHAVIOUR
//  - inta_n passes through SYNC_STAGES flops (reset to 1) -> inta_s; FSM acts on inta_s edges; outputs registered (1 clk after edge).
//  - Reset: all outputs 0, state IDLE, synchronizer 1s, timer 0; reset mid-cycle drops cas_oe/vec_oe immediately (async).
//  - Mode master = buf_mode ? buf_ms : sp_en_n; sampled and held on IDLE->ACK1.
//  - States: IDLE, ACK1, GAP, ACK2.
//  - IDLE->ACK1 on inta_s falling: latch isr_level = int_req ? int_level : 3'd7; spurious = ~int_req;
//    master: isr_set pulse if int_req; cas_out = isr_level and cas_oe = 1 if slave_map[isr_level], else cas_oe = 0.
//  - ACK1->GAP on inta_s rising: slave registers match = (cas_in == slave_id); slave with match and int_req pulses isr_set (level captured at ACK1 entry).
//  - GAP: timer counts from 0; inta_s falling -> ACK2; timer reaching GAP_TIMEOUT-1 -> IDLE, ack_abort pulse, cas_oe=0, no vec_oe.
//  - ACK2: vec_oe = 1 if (master & ~slave_map[isr_level]) | (master & spurious) | (slave & match); cas_oe held.
//  - ACK2->IDLE on inta_s rising: vec_oe, cas_oe, spurious cleared same edge.
//  - Master with cascaded IR never asserts vec_oe; slave never asserts cas_oe.
//  - int_level/int_req changes after ACK1 entry ignored until IDLE.
//  - inta_n glitch shorter than SYNC_STAGES clks may be missed; no partial-state recovery other than timeout.
//  - isr_set at most once per acknowledge cycle; never on spurious or abort.
// TESTING
//  1 master, slave_map=8'h00, int_req=1, int_level=3, two INTA pulses -> isr_set once with isr_level=3, cas_oe=0, vec_oe=1 only during 2nd pulse.
//  2 master, slave_map=8'h04, int_level=2 -> cas_out=3'd2, cas_oe=1 from 1st INTA to end of 2nd, vec_oe never asserted.
//  3 slave, slave_id=2, cas_in=2 during 1st INTA -> isr_set after 1st rising edge, vec_oe=1 in 2nd pulse; cas_in=5 -> no isr_set, no vec_oe.
//  4 master, int_req=0 at 1st INTA -> spurious=1, isr_level=7, no isr_set, vec_oe=1 in 2nd pulse.
//  5 single INTA then hold high GAP_TIMEOUT clks -> ack_abort pulse, cas_oe=0, FSM IDLE; next pair acknowledges normally.
//  6 assert rst during ACK2 -> cas_oe, vec_oe, spurious drop without clock; FSM IDLE after release.

Source files
------------

// File: rtl/inta_cascade_sequencer_if.sv
// Acknowledge/cascade bundle between the CPU-side INTA, ICW config, resolver and CAS/data-bus pins.
// master = stimulus side (CPU, resolver, config); slave = the sequencer itself.
interface inta_cascade_sequencer_if;
    logic       inta_n;
    logic       sp_en_n;
    logic       buf_mode;
    logic       buf_ms;
    logic [7:0] slave_map;
    logic [2:0] slave_id;
    logic       int_req;
    logic [2:0] int_level;
    logic [2:0] cas_in;
    logic [2:0] cas_out;
    logic       cas_oe;
    logic       isr_set;
    logic [2:0] isr_level;
    logic       vec_oe;
    logic       spurious;
    logic       ack_abort;

    modport master (
        output inta_n, sp_en_n, buf_mode, buf_ms, slave_map, slave_id,
               int_req, int_level, cas_in,
        input  cas_out, cas_oe, isr_set, isr_level, vec_oe, spurious, ack_abort
    );

    modport slave (
        input  inta_n, sp_en_n, buf_mode, buf_ms, slave_map, slave_id,
               int_req, int_level, cas_in,
        output cas_out, cas_oe, isr_set, isr_level, vec_oe, spurious, ack_abort
    );
endinterface

// File: rtl/inta_cascade_sequencer.sv
// Two-pulse INTA acknowledge sequencer with CAS cascade handling for master and slave PICs.
// inta_n is synchronized first; the FSM reacts to edges of the synchronized strobe.
module inta_cascade_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int GAP_TIMEOUT = 64
) (
    input logic                   clk,
    input logic                   rst,
    inta_cascade_sequencer_if.slave bus
);

    localparam int TW = (GAP_TIMEOUT > 2) ? $clog2(GAP_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] inta_sync_p0;
    logic                   inta_s;
    logic                   inta_s_p1;
    logic                   inta_fall;
    logic                   inta_rise;
    logic                   mode_master;
    logic                   master_q;
    logic                   match_q;
    logic                   req_q;
    logic [2:0]             level_nxt;
    logic [TW-1:0]          timer;

    assign inta_s      = inta_sync_p0[SYNC_STAGES-1];
    assign inta_fall   = inta_s_p1 & ~inta_s;
    assign inta_rise   = ~inta_s_p1 & inta_s;
    assign mode_master = bus.buf_mode ? bus.buf_ms : bus.sp_en_n;
    assign level_nxt   = bus.int_req ? bus.int_level : 3'd7;

    // Synchronizer stage: idles high so reset never looks like an INTA edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inta_sync_p0 <= '1;
            inta_s_p1    <= 1'b1;
        end else begin
            inta_sync_p0 <= {inta_sync_p0[SYNC_STAGES-2:0], bus.inta_n};
            inta_s_p1    <= inta_s;
        end
    end

    // Sequencer stage: all outputs registered, one clock after the detected edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            master_q      <= 1'b0;
            match_q       <= 1'b0;
            req_q         <= 1'b0;
            timer         <= '0;
            bus.cas_out   <= 3'd0;
            bus.cas_oe    <= 1'b0;
            bus.isr_set   <= 1'b0;
            bus.isr_level <= 3'd0;
            bus.vec_oe    <= 1'b0;
            bus.spurious  <= 1'b0;
            bus.ack_abort <= 1'b0;
        end else begin
            bus.isr_set   <= 1'b0;
            bus.ack_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (inta_fall) begin
                        state         <= ACK1;
                        master_q      <= mode_master;
                        req_q         <= bus.int_req;
                        match_q       <= 1'b0;
                        bus.isr_level <= level_nxt;
                        bus.spurious  <= ~bus.int_req;
                        bus.isr_set   <= mode_master & bus.int_req;
                        bus.cas_out   <= level_nxt;
                        bus.cas_oe    <= mode_master & bus.slave_map[level_nxt];
                    end
                end
                ACK1: begin
                    if (inta_rise) begin
                        state <= GAP;
                        timer <= '0;
                        if (!master_q) begin
                            match_q     <= (bus.cas_in == bus.slave_id);
                            bus.isr_set <= req_q & (bus.cas_in == bus.slave_id);
                        end
                    end
                end
                GAP: begin
                    if (inta_fall) begin
                        state      <= ACK2;
                        bus.vec_oe <= master_q ? (~bus.slave_map[bus.isr_level] | bus.spurious)
                                               : match_q;
                    end else if (timer == TW'(GAP_TIMEOUT - 1)) begin
                        // Second INTA never came: give up the cycle and release CAS
                        state         <= IDLE;
                        bus.ack_abort <= 1'b1;
                        bus.cas_oe    <= 1'b0;
                        bus.spurious  <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ACK2: begin
                    if (inta_rise) begin
                        state        <= IDLE;
                        bus.vec_oe   <= 1'b0;
                        bus.cas_oe   <= 1'b0;
                        bus.spurious <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inta_cascade_sequencer.sv
// Directed bench for inta_cascade_sequencer: master, slave, spurious, timeout and reset scenarios.
module tb_inta_cascade_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   isr_cnt;
    int   vec_cnt;
    int   abort_cnt;

    inta_cascade_sequencer_if bus ();

    inta_cascade_sequencer #(.SYNC_STAGES(2), .GAP_TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.isr_set)   isr_cnt   = isr_cnt + 1;
        if (bus.vec_oe)    vec_cnt   = vec_cnt + 1;
        if (bus.ack_abort) abort_cnt = abort_cnt + 1;
    end

    task automatic clear_counts();
        isr_cnt   = 0;
        vec_cnt   = 0;
        abort_cnt = 0;
    endtask

    // Hold inta_n at a level for six clocks; returns on a falling clock edge
    task automatic phase(input logic lvl);
        bus.inta_n = lvl;
        repeat (6) @(negedge clk);
    endtask

    task automatic config_master(input logic [7:0] map, input logic req, input logic [2:0] lvl);
        bus.sp_en_n   = 1'b1;
        bus.buf_mode  = 1'b0;
        bus.buf_ms    = 1'b0;
        bus.slave_map = map;
        bus.int_req   = req;
        bus.int_level = lvl;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.inta_n = 1'b1;
        config_master(8'h00, 1'b0, 3'd0);
        bus.slave_id = 3'd0;
        bus.cas_in   = 3'd0;
        clear_counts();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.cas_out, bus.cas_oe, bus.isr_set, bus.isr_level, bus.vec_oe, bus.spurious, bus.ack_abort} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {bus.cas_out, bus.cas_oe, bus.isr_set, bus.isr_level, bus.vec_oe, bus.spurious, bus.ack_abort});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_master_plain();
        config_master(8'h00, 1'b1, 3'd3);
        clear_counts();
        phase(1'b0);
        n_cmp++;
        if (bus.isr_level !== 3'd3 || bus.cas_oe !== 1'b0 || bus.vec_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL plain_ack1: got lvl=%0d cas_oe=%b vec_oe=%b expected 3 0 0", bus.isr_level, bus.cas_oe, bus.vec_oe);
        end
        bus.int_level = 3'd6;
        phase(1'b1);
        phase(1'b0);
        n_cmp++;
        if (bus.vec_oe !== 1'b1 || bus.isr_level !== 3'd3) begin
            n_bad++;
            $display("FAIL plain_ack2: got vec_oe=%b lvl=%0d expected 1 3", bus.vec_oe, bus.isr_level);
        end
        phase(1'b1);
        n_cmp++;
        if (isr_cnt !== 1 || vec_cnt !== 6 || bus.vec_oe !== 1'b0 || bus.spurious !== 1'b0) begin
            n_bad++;
            $display("FAIL plain_end: got isr_cnt=%0d vec_cnt=%0d vec_oe=%b spur=%b expected 1 6 0 0",
                     isr_cnt, vec_cnt, bus.vec_oe, bus.spurious);
        end
    endtask

    task automatic test_master_cascade();
        config_master(8'h04, 1'b1, 3'd2);
        clear_counts();
        phase(1'b0);
        n_cmp++;
        if (bus.cas_out !== 3'd2 || bus.cas_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL cascade_ack1: got cas_out=%0d cas_oe=%b expected 2 1", bus.cas_out, bus.cas_oe);
        end
        phase(1'b1);
        n_cmp++;
        if (bus.cas_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL cascade_gap: got cas_oe=%b expected 1", bus.cas_oe);
        end
        phase(1'b0);
        n_cmp++;
        if (bus.cas_oe !== 1'b1 || bus.cas_out !== 3'd2 || bus.vec_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL cascade_ack2: got cas_oe=%b cas_out=%0d vec_oe=%b expected 1 2 0", bus.cas_oe, bus.cas_out, bus.vec_oe);
        end
        phase(1'b1);
        n_cmp++;
        if (bus.cas_oe !== 1'b0 || vec_cnt !== 0 || isr_cnt !== 1) begin
            n_bad++;
            $display("FAIL cascade_end: got cas_oe=%b vec_cnt=%0d isr_cnt=%0d expected 0 0 1", bus.cas_oe, vec_cnt, isr_cnt);
        end
    endtask

    task automatic test_slave();
        config_master(8'h00, 1'b1, 3'd4);
        bus.sp_en_n  = 1'b0;
        bus.slave_id = 3'd2;
        bus.cas_in   = 3'd2;
        clear_counts();
        phase(1'b0);
        n_cmp++;
        if (isr_cnt !== 0 || bus.cas_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL slave_ack1: got isr_cnt=%0d cas_oe=%b expected 0 0", isr_cnt, bus.cas_oe);
        end
        phase(1'b1);
        bus.cas_in = 3'd0;
        n_cmp++;
        if (isr_cnt !== 1 || bus.isr_level !== 3'd4) begin
            n_bad++;
            $display("FAIL slave_match_isr: got isr_cnt=%0d lvl=%0d expected 1 4", isr_cnt, bus.isr_level);
        end
        phase(1'b0);
        n_cmp++;
        if (bus.vec_oe !== 1'b1 || bus.cas_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL slave_match_vec: got vec_oe=%b cas_oe=%b expected 1 0", bus.vec_oe, bus.cas_oe);
        end
        phase(1'b1);
        bus.cas_in = 3'd5;
        clear_counts();
        phase(1'b0);
        phase(1'b1);
        phase(1'b0);
        n_cmp++;
        if (bus.vec_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL slave_nomatch_vec: got vec_oe=%b expected 0", bus.vec_oe);
        end
        phase(1'b1);
        n_cmp++;
        if (isr_cnt !== 0 || vec_cnt !== 0) begin
            n_bad++;
            $display("FAIL slave_nomatch_cnt: got isr_cnt=%0d vec_cnt=%0d expected 0 0", isr_cnt, vec_cnt);
        end
    endtask

    task automatic test_buf_mode();
        config_master(8'h00, 1'b1, 3'd6);
        bus.sp_en_n  = 1'b0;
        bus.buf_mode = 1'b1;
        bus.buf_ms   = 1'b1;
        bus.cas_in   = 3'd7;
        bus.slave_id = 3'd0;
        clear_counts();
        phase(1'b0);
        n_cmp++;
        if (isr_cnt !== 1 || bus.isr_level !== 3'd6) begin
            n_bad++;
            $display("FAIL bufmode_master: got isr_cnt=%0d lvl=%0d expected 1 6", isr_cnt, bus.isr_level);
        end
        phase(1'b1);
        phase(1'b0);
        n_cmp++;
        if (bus.vec_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL bufmode_vec: got vec_oe=%b expected 1", bus.vec_oe);
        end
        phase(1'b1);
    endtask

    task automatic test_spurious();
        config_master(8'h00, 1'b0, 3'd1);
        clear_counts();
        phase(1'b0);
        n_cmp++;
        if (bus.spurious !== 1'b1 || bus.isr_level !== 3'd7) begin
            n_bad++;
            $display("FAIL spur_ack1: got spur=%b lvl=%0d expected 1 7", bus.spurious, bus.isr_level);
        end
        bus.int_req = 1'b1;
        phase(1'b1);
        phase(1'b0);
        n_cmp++;
        if (bus.vec_oe !== 1'b1 || bus.spurious !== 1'b1) begin
            n_bad++;
            $display("FAIL spur_ack2: got vec_oe=%b spur=%b expected 1 1", bus.vec_oe, bus.spurious);
        end
        phase(1'b1);
        n_cmp++;
        if (isr_cnt !== 0 || bus.spurious !== 1'b0) begin
            n_bad++;
            $display("FAIL spur_end: got isr_cnt=%0d spur=%b expected 0 0", isr_cnt, bus.spurious);
        end
    endtask

    task automatic test_timeout();
        config_master(8'h04, 1'b1, 3'd2);
        clear_counts();
        phase(1'b0);
        bus.inta_n = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (abort_cnt !== 0 || bus.cas_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_early: got aborts=%0d cas_oe=%b expected 0 1", abort_cnt, bus.cas_oe);
        end
        repeat (40) @(negedge clk);
        n_cmp++;
        if (abort_cnt !== 1 || bus.cas_oe !== 1'b0 || vec_cnt !== 0) begin
            n_bad++;
            $display("FAIL timeout_abort: got aborts=%0d cas_oe=%b vec_cnt=%0d expected 1 0 0", abort_cnt, bus.cas_oe, vec_cnt);
        end
        config_master(8'h00, 1'b1, 3'd5);
        clear_counts();
        phase(1'b0);
        phase(1'b1);
        phase(1'b0);
        n_cmp++;
        if (bus.vec_oe !== 1'b1 || bus.isr_level !== 3'd5 || isr_cnt !== 1) begin
            n_bad++;
            $display("FAIL timeout_recover: got vec_oe=%b lvl=%0d isr_cnt=%0d expected 1 5 1", bus.vec_oe, bus.isr_level, isr_cnt);
        end
        phase(1'b1);
    endtask

    task automatic test_reset_in_ack2();
        config_master(8'h80, 1'b0, 3'd0);
        clear_counts();
        phase(1'b0);
        phase(1'b1);
        phase(1'b0);
        n_cmp++;
        if (bus.cas_oe !== 1'b1 || bus.vec_oe !== 1'b1 || bus.spurious !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre: got cas_oe=%b vec_oe=%b spur=%b expected 1 1 1", bus.cas_oe, bus.vec_oe, bus.spurious);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.cas_oe !== 1'b0 || bus.vec_oe !== 1'b0 || bus.spurious !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: got cas_oe=%b vec_oe=%b spur=%b expected 0 0 0", bus.cas_oe, bus.vec_oe, bus.spurious);
        end
        bus.inta_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        clear_counts();
        repeat (6) @(negedge clk);
        n_cmp++;
        if (bus.cas_oe !== 1'b0 || vec_cnt !== 0 || isr_cnt !== 0) begin
            n_bad++;
            $display("FAIL rst_idle: got cas_oe=%b vec_cnt=%0d isr_cnt=%0d expected 0 0 0", bus.cas_oe, vec_cnt, isr_cnt);
        end
        config_master(8'h00, 1'b1, 3'd1);
        phase(1'b0);
        n_cmp++;
        if (bus.isr_level !== 3'd1 || isr_cnt !== 1 || bus.vec_oe !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_next_ack1: got lvl=%0d isr_cnt=%0d vec_oe=%b expected 1 1 0", bus.isr_level, isr_cnt, bus.vec_oe);
        end
        phase(1'b1);
        phase(1'b0);
        n_cmp++;
        if (bus.vec_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_next_ack2: got vec_oe=%b expected 1", bus.vec_oe);
        end
        phase(1'b1);
    endtask

    initial begin
        test_reset();
        test_master_plain();
        test_master_cascade();
        test_slave();
        test_buf_mode();
        test_spurious();
        test_timeout();
        test_reset_in_ack2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
